// File: rtl/fft_mag_spectrum_pkg.sv
// fft_mag_pkg: shared defaults, width helper and bank-state type for the
// FFT magnitude-spectrum stage (fft_mag_spectrum and its sub-modules).
// No ports.

package fft_mag_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_IDX_W  = 10;
  localparam int unsigned DEF_DROP_W = 8;

  // Width of an unsigned re^2 + im^2 result.
  function automatic int unsigned mag_w(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

endpackage

// File: rtl/fft_mag_spectrum_if.sv
// fft_mag_spectrum_if: bundles the FFT output stream, the magnitude stream and
// the spectrum reader handshake of fft_mag_spectrum.
//   master : FFT core + spectrum reader side (drives xk_*, rd_addr, rd_release)
//   slave  : fft_mag_spectrum (drives mag_*, frame_ready, rd_data, peak_*, drop_cnt)

interface fft_mag_spectrum_if
  import fft_mag_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned DROP_W = DEF_DROP_W
);

  logic                       xk_dv;
  logic        [IDX_W-1:0]    xk_index;
  logic signed [DATA_W-1:0]   xk_re;
  logic signed [DATA_W-1:0]   xk_im;

  logic                       mag_valid;
  logic        [IDX_W-1:0]    mag_index;
  logic        [2*DATA_W-1:0] mag_out;

  logic                       frame_ready;
  logic        [IDX_W-1:0]    rd_addr;
  logic        [2*DATA_W-1:0] rd_data;
  logic                       rd_release;
  logic        [2*DATA_W-1:0] peak_mag;
  logic        [IDX_W-1:0]    peak_idx;
  logic        [DROP_W-1:0]   drop_cnt;

  modport master (
    output xk_dv, xk_index, xk_re, xk_im, rd_addr, rd_release,
    input  mag_valid, mag_index, mag_out, frame_ready, rd_data, peak_mag, peak_idx, drop_cnt
  );

  modport slave (
    input  xk_dv, xk_index, xk_re, xk_im, rd_addr, rd_release,
    output mag_valid, mag_index, mag_out, frame_ready, rd_data, peak_mag, peak_idx, drop_cnt
  );

endinterface

// File: rtl/fft_mag_spectrum_mag_sq_pipe.sv
// mag_sq_pipe: two-stage registered |X|^2 pipeline.
//   Stage 1 registers re*re and im*im on in_dv; stage 2 sums them.
//   Valid and index travel alongside the data; bubbles propagate as out_valid=0.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_dv/in_index      input sample valid and bin index
//   in_re/in_im         signed input sample
//   out_valid/out_index result valid (2 cycles after in_dv) and its index
//   out_mag             unsigned re^2 + im^2

module mag_sq_pipe
  import fft_mag_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_dv,
  input  logic        [IDX_W-1:0]        in_index,
  input  logic signed [DATA_W-1:0]       in_re,
  input  logic signed [DATA_W-1:0]       in_im,
  output logic                           out_valid,
  output logic        [IDX_W-1:0]        out_index,
  output logic        [mag_w(DATA_W)-1:0] out_mag
);

  localparam int unsigned MagW = mag_w(DATA_W);

  // Operands are sign-extended to full width first so the product is not
  // truncated to DATA_W bits. Squares are non-negative, so the top bit of each
  // product is always zero and the stage-2 sum cannot overflow.
  logic signed [MagW-1:0] re_ext, im_ext;
  logic        [MagW-1:0] re_sq_d, im_sq_d;

  assign re_ext  = {{DATA_W{in_re[DATA_W-1]}}, in_re};
  assign im_ext  = {{DATA_W{in_im[DATA_W-1]}}, im_ext_lo()};
  assign re_sq_d = re_ext * re_ext;
  assign im_sq_d = im_ext * im_ext;

  function automatic logic [DATA_W-1:0] im_ext_lo();
    return in_im;
  endfunction

  logic             s1_valid_q;
  logic [IDX_W-1:0] s1_index_q;
  logic [MagW-1:0]  re_sq_q, im_sq_q;

  logic             s2_valid_q;
  logic [IDX_W-1:0] s2_index_q;
  logic [MagW-1:0]  s2_mag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_index_q <= '0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
    end else begin
      s1_valid_q <= in_dv;
      if (in_dv) begin
        s1_index_q <= in_index;
        re_sq_q    <= re_sq_d;
        im_sq_q    <= im_sq_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_index_q <= '0;
      s2_mag_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_index_q <= s1_index_q;
        s2_mag_q   <= re_sq_q + im_sq_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_index = s2_index_q;
  assign out_mag   = s2_mag_q;

endmodule

// File: rtl/fft_mag_spectrum.sv
// fft_mag_spectrum: FFT output magnitude stage with double-buffered spectrum RAM.
//   Streams |X|^2 per bin, writes each result into the write bank, and on the
//   bin N-1 write hands the completed frame to the reader (bank swap) unless the
//   reader still holds the read bank, in which case the frame is dropped.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fft_mag_spectrum_if.slave (FFT stream in, magnitude stream out,
//                read port rd_addr/rd_data, frame_ready/rd_release handshake,
//                peak_mag/peak_idx, drop_cnt)
// Build option: define FFT_MAG_PEAK_EN to include the running-peak tracker;
// without it peak_mag/peak_idx are tied to zero.

module fft_mag_spectrum
  import fft_mag_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned DROP_W = DEF_DROP_W
) (
  input logic               clk,
  input logic               rst_n,
  fft_mag_spectrum_if.slave bus
);

  localparam int unsigned MagW  = mag_w(DATA_W);
  localparam int unsigned Depth = 2 * (1 << IDX_W);

  logic             mag_valid;
  logic [IDX_W-1:0] mag_index;
  logic [MagW-1:0]  mag_out;

  mag_sq_pipe #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mag_sq_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dv     (bus.xk_dv),
    .in_index  (bus.xk_index),
    .in_re     (bus.xk_re),
    .in_im     (bus.xk_im),
    .out_valid (mag_valid),
    .out_index (mag_index),
    .out_mag   (mag_out)
  );

  assign bus.mag_valid = mag_valid;
  assign bus.mag_index = mag_index;
  assign bus.mag_out   = mag_out;

  bank_state_e      state_q;
  logic             wr_bank_q;
  logic             frame_ready_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [MagW-1:0]  rd_data_q;
  logic             frame_done;

  assign frame_done = mag_valid & (&mag_index);

  // Spectrum RAM, addressed {bank, index}; not cleared by reset. Writes are
  // gated by rst_n so a sample in flight during reset never lands.
  logic [MagW-1:0] ram_q [Depth];

  always_ff @(posedge clk) begin
    if (rst_n && mag_valid) begin
      ram_q[{wr_bank_q, mag_index}] <= mag_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= ram_q[{~wr_bank_q, bus.rd_addr}];
    end
  end

`ifdef FFT_MAG_PEAK_EN
  // Running peak over the frame being written; run_*_d already includes the
  // current sample so the bin N-1 value is seen when latching at frame end.
  logic [MagW-1:0]  run_peak_q, run_peak_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [MagW-1:0]  peak_mag_q;
  logic [IDX_W-1:0] peak_idx_q;

  always_comb begin
    run_peak_d = run_peak_q;
    run_idx_d  = run_idx_q;
    // Strictly greater: on ties the earlier (lower) bin wins.
    if (mag_valid && ((mag_index == '0) || (mag_out > run_peak_q))) begin
      run_peak_d = mag_out;
      run_idx_d  = mag_index;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_peak_q <= '0;
      run_idx_q  <= '0;
    end else begin
      run_peak_q <= run_peak_d;
      run_idx_q  <= run_idx_d;
    end
  end

  assign bus.peak_mag = peak_mag_q;
  assign bus.peak_idx = peak_idx_q;
`else
  assign bus.peak_mag = '0;
  assign bus.peak_idx = '0;
`endif

  // Bank FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BANK_EMPTY;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      drop_cnt_q    <= '0;
`ifdef FFT_MAG_PEAK_EN
      peak_mag_q    <= '0;
      peak_idx_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        BANK_EMPTY: begin
          // rd_release is ignored here.
          if (frame_done) begin
            state_q       <= BANK_FULL;
            wr_bank_q     <= ~wr_bank_q;
            frame_ready_q <= 1'b1;
`ifdef FFT_MAG_PEAK_EN
            peak_mag_q    <= run_peak_d;
            peak_idx_q    <= run_idx_d;
`endif
          end
        end
        BANK_FULL: begin
          if (bus.rd_release && frame_done) begin
            // Release wins over drop: the new frame is handed over directly.
            wr_bank_q <= ~wr_bank_q;
`ifdef FFT_MAG_PEAK_EN
            peak_mag_q <= run_peak_d;
            peak_idx_q <= run_idx_d;
`endif
          end else if (bus.rd_release) begin
            state_q       <= BANK_EMPTY;
            frame_ready_q <= 1'b0;
          end else if (frame_done) begin
            if (drop_cnt_q != '1) begin
              drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            end
          end
        end
        default: begin
          state_q       <= BANK_EMPTY;
          frame_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame_ready = frame_ready_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_fft_mag_spectrum.sv
// Self-checking bench for fft_mag_spectrum: randomized frames and streams
// compared against a behavioural model of |X|^2, the bank handoff rules,
// the dropped-frame counter and the frame peak.

module tb_fft_mag_spectrum;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned N      = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_mag_spectrum_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DROP_W(DROP_W)) bus ();

  fft_mag_spectrum #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic signed [15:0] frm_re [N];
  logic signed [15:0] frm_im [N];
  logic [31:0] frm_mag [N];
  logic [31:0] rb_mag [N];
  logic        exp_ready;
  logic [7:0]  exp_drop;
  logic [31:0] exp_pk_mag;
  logic [9:0]  exp_pk_idx;

  function automatic logic [31:0] ref_mag(input logic signed [15:0] re,
                                          input logic signed [15:0] im);
    longint r, i;
    r = longint'(re);
    i = longint'(im);
    return 32'(r * r + i * i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.xk_dv      = 1'b0;
    bus.xk_index   = '0;
    bus.xk_re      = '0;
    bus.xk_im      = '0;
    bus.rd_release = 1'b0;
    bus.rd_addr    = '0;
  endtask

  // mode 0: random; 1: spike (1000,0) at bin 300; 2: tie of 490000 at bins 100 and 200
  task automatic gen_frame(input int mode);
    for (int k = 0; k < int'(N); k++) begin
      frm_re[k] = 16'($signed($urandom_range(0, 800)) - 400);
      frm_im[k] = 16'($signed($urandom_range(0, 800)) - 400);
    end
    if (mode == 1) begin
      frm_re[300] = 16'sd1000;
      frm_im[300] = 16'sd0;
    end else if (mode == 2) begin
      frm_re[100] = 16'sd700;
      frm_im[100] = 16'sd0;
      frm_re[200] = 16'sd0;
      frm_im[200] = -16'sd700;
    end
    for (int k = 0; k < int'(N); k++) frm_mag[k] = ref_mag(frm_re[k], frm_im[k]);
  endtask

  // Streams the current frame back to back and applies the handoff rules.
  task automatic send_frame(input string name, input bit release_at_end);
    logic p_dv, c_dv;
    logic [9:0] p_idx, c_idx;
    logic [31:0] p_mag, c_mag;
    logic [31:0] fpk;
    logic [9:0] fpk_i;
    p_dv = 1'b0; p_idx = '0; p_mag = '0;
    for (int t = 0; t <= int'(N) + 1; t++) begin
      c_dv  = (t < int'(N));
      c_idx = 10'(t);
      c_mag = c_dv ? frm_mag[t] : 32'd0;
      bus.xk_dv      = c_dv;
      bus.xk_index   = c_idx;
      bus.xk_re      = c_dv ? frm_re[t] : 16'sd0;
      bus.xk_im      = c_dv ? frm_im[t] : 16'sd0;
      bus.rd_release = release_at_end && (t == int'(N) + 1);
      step();
      checks++;
      if (bus.mag_valid !== p_dv) begin
        errors++;
        $display("FAIL %s stream valid t=%0d: got %b want %b", name, t, bus.mag_valid, p_dv);
      end
      if (p_dv) begin
        checks++;
        if (bus.mag_index !== p_idx || bus.mag_out !== p_mag) begin
          errors++;
          $display("FAIL %s stream data t=%0d: got idx=%0d mag=%0d want idx=%0d mag=%0d",
                   name, t, bus.mag_index, bus.mag_out, p_idx, p_mag);
        end
      end
      if (t == int'(N)) begin
        checks++;
        if (bus.frame_ready !== exp_ready) begin
          errors++;
          $display("FAIL %s ready before handoff: got %b want %b", name, bus.frame_ready,
                   exp_ready);
        end
      end
      p_dv = c_dv; p_idx = c_idx; p_mag = c_mag;
    end
    idle_inputs();
    // Frame peak: first occurrence of the maximum in index order.
    fpk = frm_mag[0]; fpk_i = '0;
    for (int k = 1; k < int'(N); k++) begin
      if (frm_mag[k] > fpk) begin
        fpk = frm_mag[k];
        fpk_i = 10'(k);
      end
    end
    if (!exp_ready || release_at_end) begin
      for (int k = 0; k < int'(N); k++) rb_mag[k] = frm_mag[k];
      exp_ready = 1'b1;
`ifdef FFT_MAG_PEAK_EN
      exp_pk_mag = fpk;
      exp_pk_idx = fpk_i;
`endif
    end else if (exp_drop != 8'hFF) begin
      exp_drop = exp_drop + 8'd1;
    end
    checks++;
    if (bus.frame_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s ready after handoff: got %b want %b", name, bus.frame_ready, exp_ready);
    end
    checks++;
    if (bus.drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL %s drop_cnt: got %0d want %0d", name, bus.drop_cnt, exp_drop);
    end
    checks++;
    if (bus.peak_mag !== exp_pk_mag || bus.peak_idx !== exp_pk_idx) begin
      errors++;
      $display("FAIL %s peak: got mag=%0d idx=%0d want mag=%0d idx=%0d", name, bus.peak_mag,
               bus.peak_idx, exp_pk_mag, exp_pk_idx);
    end
  endtask

  task automatic test_read_port(input string name);
    logic [9:0] addrs [7];
    addrs[0] = 10'd300; addrs[1] = 10'd0; addrs[2] = 10'd1023;
    for (int i = 3; i < 7; i++) addrs[i] = 10'($urandom_range(0, N - 1));
    for (int i = 0; i < 7; i++) begin
      bus.rd_addr = addrs[i];
      step();
      checks++;
      if (bus.rd_data !== rb_mag[addrs[i]]) begin
        errors++;
        $display("FAIL %s read addr=%0d: got %0d want %0d", name, addrs[i], bus.rd_data,
                 rb_mag[addrs[i]]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    checks++;
    if (bus.mag_valid !== 1'b0 || bus.mag_index !== 10'd0 || bus.mag_out !== 32'd0) begin
      errors++;
      $display("FAIL reset stream: got v=%b idx=%0d mag=%0d want 0", bus.mag_valid,
               bus.mag_index, bus.mag_out);
    end
    checks++;
    if (bus.frame_ready !== 1'b0 || bus.rd_data !== 32'd0 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset bank: got ready=%b rd=%0d drop=%0d want 0", bus.frame_ready,
               bus.rd_data, bus.drop_cnt);
    end
    checks++;
    if (bus.peak_mag !== 32'd0 || bus.peak_idx !== 10'd0) begin
      errors++;
      $display("FAIL reset peak: got %0d/%0d want 0", bus.peak_mag, bus.peak_idx);
    end
    rst_n = 1'b1;
    exp_ready = 1'b0; exp_drop = '0; exp_pk_mag = '0; exp_pk_idx = '0;
    step();
  endtask

  task automatic test_single(input string name, input logic signed [15:0] re,
                             input logic signed [15:0] im, input logic [9:0] idx,
                             input logic [31:0] want);
    bus.xk_dv = 1'b1; bus.xk_re = re; bus.xk_im = im; bus.xk_index = idx;
    step();
    idle_inputs();
    checks++;
    if (bus.mag_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early valid: got %b want 0", name, bus.mag_valid);
    end
    step();
    checks++;
    if (bus.mag_valid !== 1'b1 || bus.mag_index !== idx || bus.mag_out !== want) begin
      errors++;
      $display("FAIL %s result: got v=%b idx=%0d mag=%0h want v=1 idx=%0d mag=%0h", name,
               bus.mag_valid, bus.mag_index, bus.mag_out, idx, want);
    end
    step();
    checks++;
    if (bus.mag_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s trailing valid: got %b want 0", name, bus.mag_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic p_dv, p2_dv, c_dv;
    logic [9:0] p_idx, p2_idx, c_idx;
    logic [31:0] p_mag, p2_mag, c_mag;
    logic signed [15:0] re, im;
    p_dv = 1'b0; p_idx = '0; p_mag = '0;
    for (int t = 0; t < 300; t++) begin
      c_dv  = ($urandom_range(0, 9) < 7);
      c_idx = 10'($urandom_range(0, N - 2));
      re    = 16'($urandom);
      im    = 16'($urandom);
      c_mag = ref_mag(re, im);
      bus.xk_dv = c_dv; bus.xk_index = c_idx; bus.xk_re = re; bus.xk_im = im;
      step();
      checks++;
      if (bus.mag_valid !== p_dv || (p_dv && (bus.mag_index !== p_idx || bus.mag_out !== p_mag)))
      begin
        errors++;
        $display("FAIL back_to_back t=%0d: got v=%b idx=%0d mag=%0h want v=%b idx=%0d mag=%0h",
                 t, bus.mag_valid, bus.mag_index, bus.mag_out, p_dv, p_idx, p_mag);
      end
      p2_dv = c_dv; p2_idx = c_idx; p2_mag = c_mag;
      p_dv = p2_dv; p_idx = p2_idx; p_mag = p2_mag;
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_release();
    bus.rd_release = 1'b1;
    step();
    bus.rd_release = 1'b0;
    exp_ready = 1'b0;
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL release: got ready=%b want 0", bus.frame_ready);
    end
    bus.rd_release = 1'b1;
    step();
    bus.rd_release = 1'b0;
    step();
    checks++;
    if (bus.frame_ready !== 1'b0 || bus.drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL release while empty: got ready=%b drop=%0d want 0/%0d", bus.frame_ready,
               bus.drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset_mid_frame();
    gen_frame(0);
    for (int t = 0; t <= 512; t++) begin
      bus.xk_dv = 1'b1; bus.xk_index = 10'(t); bus.xk_re = frm_re[t]; bus.xk_im = frm_im[t];
      if (t == 512) rst_n = 1'b0;
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    exp_ready = 1'b0; exp_drop = '0; exp_pk_mag = '0; exp_pk_idx = '0;
    checks++;
    if (bus.mag_valid !== 1'b0 || bus.mag_index !== 10'd0 || bus.mag_out !== 32'd0 ||
        bus.frame_ready !== 1'b0 || bus.rd_data !== 32'd0 || bus.peak_mag !== 32'd0 ||
        bus.peak_idx !== 10'd0 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset outputs: got v=%b idx=%0d mag=%0d rdy=%b rd=%0d pk=%0d/%0d drop=%0d want all 0",
               bus.mag_valid, bus.mag_index, bus.mag_out, bus.frame_ready, bus.rd_data,
               bus.peak_mag, bus.peak_idx, bus.drop_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.mag_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset flush %0d: got valid=%b want 0", i, bus.mag_valid);
      end
    end
    gen_frame(1);
    send_frame("after_reset", 1'b0);
    test_read_port("after_reset");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single("single", 16'sd3, -16'sd4, 10'd5, 32'd25);
    test_single("extreme", -16'sd32768, -16'sd32768, 10'd7, 32'h8000_0000);
    test_back_to_back();
    gen_frame(1);
    send_frame("frame_a", 1'b0);
    test_read_port("frame_a");
    gen_frame(0);
    send_frame("frame_b_drop", 1'b0);
    test_read_port("frame_b_drop");
    gen_frame(2);
    send_frame("frame_c_collide", 1'b1);
    test_read_port("frame_c_collide");
    test_release();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
